// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: requester handshake plus the registered register-file write port.
// master = writeback sources / register file side, slave = the arbiter.
interface rf_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    localparam int SW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_rd;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               RegWrite;
    logic [AW-1:0]      rd_addr;
    logic [DW-1:0]      WriteData;
    logic [SW-1:0]      wb_src;
    logic [7:0]         busy_cnt;

    modport master (
        output req_valid, req_rd, req_data,
        input  req_ready, RegWrite, rd_addr, WriteData, wb_src, busy_cnt
    );

    modport slave (
        input  req_valid, req_rd, req_data,
        output req_ready, RegWrite, rd_addr, WriteData, wb_src, busy_cnt
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between NREQ writeback sources.
// x0 writes are acked immediately without a grant; the winner is registered onto the write port.
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic           clk,
    input  logic           rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int SW = $clog2(NREQ);

    logic [NREQ-1:0] x0_valid;
    logic [NREQ-1:0] nz_valid;
    logic [NREQ-1:0] grant;
    logic            found;
    int              sel_idx;
    logic            multi_req;

    logic [SW-1:0]   ptr_q;
    logic            regwrite_q;
    logic [AW-1:0]   rd_addr_q;
    logic [DW-1:0]   wdata_q;
    logic [SW-1:0]   wb_src_q;
    logic [7:0]      busy_q;
    logic [7:0]      busy_d;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign x0_valid[gi] = bus.req_valid[gi] && (bus.req_rd[gi*AW +: AW] == '0);
            assign nz_valid[gi] = bus.req_valid[gi] && (bus.req_rd[gi*AW +: AW] != '0);
        end
    endgenerate

    // Search begins one past the last winner so the previous owner is considered last.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        sel_idx = 0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && nz_valid[(int'(ptr_q) + k) % NREQ]) begin
                found   = 1'b1;
                sel_idx = (int'(ptr_q) + k) % NREQ;
            end
        end
        if (found) begin
            grant[sel_idx] = 1'b1;
        end
    end

    // Two or more competing non-x0 requests means somebody stalls this cycle.
    assign multi_req = (nz_valid & (nz_valid - 1'b1)) != '0;

    always_comb begin
        busy_d = busy_q;
        if (multi_req && busy_q != 8'hFF) begin
            busy_d = busy_q + 8'd1;
        end
    end

    assign bus.req_ready = rst ? '0 : (x0_valid | grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= SW'(NREQ - 1);
            regwrite_q <= 1'b0;
            rd_addr_q  <= '0;
            wdata_q    <= '0;
            wb_src_q   <= '0;
            busy_q     <= '0;
        end else begin
            regwrite_q <= found;
            busy_q     <= busy_d;
            if (found) begin
                ptr_q     <= SW'(sel_idx);
                wb_src_q  <= SW'(sel_idx);
                rd_addr_q <= bus.req_rd[sel_idx*AW +: AW];
                wdata_q   <= bus.req_data[sel_idx*DW +: DW];
            end
        end
    end

    assign bus.RegWrite  = regwrite_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.WriteData = wdata_q;
    assign bus.wb_src    = wb_src_q;
    assign bus.busy_cnt  = busy_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter with a small register-file model on the write port.
module tb_rf_wb_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic [DW-1:0] rf [0:31];

    rf_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.RegWrite) rf[bus.rd_addr] <= bus.WriteData;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        bus.req_rd[i*AW +: AW]   = rd;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic chk_ready(input string name, input logic [NREQ-1:0] exp);
        tests_run++;
        if (bus.req_ready !== exp) begin
            tests_failed++;
            $display("FAIL %s: req_ready=%b expected %b", name, bus.req_ready, exp);
        end
    endtask

    task automatic chk_wr(input string name, input logic we, input logic [AW-1:0] rd,
                          input logic [DW-1:0] d, input logic [1:0] src);
        tests_run++;
        if (bus.RegWrite !== we || bus.rd_addr !== rd || bus.WriteData !== d || bus.wb_src !== src) begin
            tests_failed++;
            $display("FAIL %s: we=%b rd=%0d data=%h src=%0d expected we=%b rd=%0d data=%h src=%0d",
                     name, bus.RegWrite, bus.rd_addr, bus.WriteData, bus.wb_src, we, rd, d, src);
        end else begin
            $display("[TB] %s: we=%b rd=%0d data=%h src=%0d", name, bus.RegWrite, bus.rd_addr, bus.WriteData, bus.wb_src);
        end
    endtask

    task automatic chk_we(input string name, input logic we);
        tests_run++;
        if (bus.RegWrite !== we) begin
            tests_failed++;
            $display("FAIL %s: RegWrite=%b expected %b", name, bus.RegWrite, we);
        end
    endtask

    task automatic chk_busy(input string name, input logic [7:0] exp);
        tests_run++;
        if (bus.busy_cnt !== exp) begin
            tests_failed++;
            $display("FAIL %s: busy_cnt=%0d expected %0d", name, bus.busy_cnt, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_rd    = '0;
        bus.req_data  = '0;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_rd    = '0;
        bus.req_data  = '0;
        cycle();
        cycle();
        chk_wr("reset_outputs", 1'b0, 5'd0, 32'h0, 2'd0);
        chk_busy("reset_busy", 8'd0);
        bus.req_valid = 3'b101;
        set_req(0, 5'd5, 32'h1);
        set_req(2, 5'd0, 32'h2);
        #1;
        chk_ready("reset_ready_forced", 3'b000);
        bus.req_valid = '0;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        bus.req_valid = 3'b001;
        set_req(0, 5'd5, 32'hDEADBEEF);
        #1;
        chk_ready("single_ready", 3'b001);
        cycle();
        bus.req_valid = '0;
        #1;
        chk_wr("single_write", 1'b1, 5'd5, 32'hDEADBEEF, 2'd0);
        chk_ready("single_ready_after", 3'b000);
        cycle();
        chk_wr("single_hold", 1'b0, 5'd5, 32'hDEADBEEF, 2'd0);
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.req_valid = 3'b111;
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'hA0 + 32'(i));
        for (int c = 0; c < 6; c++) begin
            int w;
            w = c % 3;
            #1;
            chk_ready($sformatf("rr_ready_%0d", c), 3'(1 << w));
            cycle();
            chk_wr($sformatf("rr_write_%0d", c), 1'b1, 5'(w + 1), 32'hA0 + 32'(w), 2'(w));
        end
        chk_busy("rr_busy", 8'd6);
        bus.req_valid = '0;
        cycle();
        chk_we("rr_idle", 1'b0);
    endtask

    task automatic test_x0_filter();
        do_reset();
        bus.req_valid = 3'b011;
        set_req(0, 5'd0, 32'h55);
        set_req(1, 5'd7, 32'h77);
        #1;
        chk_ready("x0_ready", 3'b011);
        cycle();
        bus.req_valid = '0;
        #1;
        chk_wr("x0_write_rd7", 1'b1, 5'd7, 32'h77, 2'd1);
        chk_busy("x0_no_busy", 8'd0);
        cycle();
        chk_we("x0_no_extra_write", 1'b0);
        // pointer at 1 means requester 2 is searched first
        bus.req_valid = 3'b111;
        set_req(0, 5'd1, 32'h1);
        set_req(1, 5'd2, 32'h2);
        set_req(2, 5'd3, 32'h3);
        #1;
        chk_ready("x0_ptr_is_1", 3'b100);
        bus.req_valid = '0;
        #1;
    endtask

    task automatic test_same_rd();
        do_reset();
        bus.req_valid = 3'b001;
        set_req(0, 5'd3, 32'h33);
        cycle();
        bus.req_valid = 3'b110;
        set_req(1, 5'd4, 32'h11);
        set_req(2, 5'd4, 32'h22);
        #1;
        chk_ready("same_rd_ready1", 3'b010);
        cycle();
        bus.req_valid = 3'b100;
        #1;
        chk_wr("same_rd_first", 1'b1, 5'd4, 32'h11, 2'd1);
        chk_ready("same_rd_ready2", 3'b100);
        cycle();
        bus.req_valid = '0;
        #1;
        chk_wr("same_rd_second", 1'b1, 5'd4, 32'h22, 2'd2);
        cycle();
        tests_run++;
        if (rf[4] !== 32'h22) begin
            tests_failed++;
            $display("FAIL same_rd_readback: x4=%h expected %h", rf[4], 32'h22);
        end else begin
            $display("[TB] same_rd_readback: x4=%h", rf[4]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.req_valid = 3'b110;
        set_req(1, 5'd6, 32'h66);
        set_req(2, 5'd8, 32'h88);
        for (int c = 1; c <= 300; c++) begin
            int w;
            w = (c % 2 == 1) ? 1 : 2;
            cycle();
            tests_run++;
            if (bus.RegWrite !== 1'b1 || bus.wb_src !== 2'(w)) begin
                tests_failed++;
                $display("FAIL sat_grant_%0d: we=%b src=%0d expected we=1 src=%0d", c, bus.RegWrite, bus.wb_src, w);
            end
            if (c == 254) chk_busy("sat_busy_254", 8'd254);
            if (c == 256) chk_busy("sat_busy_256", 8'd255);
        end
        chk_busy("sat_busy_300", 8'd255);
        $display("[TB] saturation: busy_cnt=%0d after 300 cycles", bus.busy_cnt);
        bus.req_valid = '0;
        #1;
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.req_valid = 3'b001;
        set_req(0, 5'd9, 32'h99);
        #1;
        chk_ready("midop_ready", 3'b001);
        cycle();
        bus.req_valid = 3'b100;
        set_req(2, 5'd10, 32'hAA);
        rst = 1'b1;
        #1;
        chk_ready("midop_ready_in_reset", 3'b000);
        cycle();
        chk_wr("midop_cancelled", 1'b0, 5'd0, 32'h0, 2'd0);
        rst = 1'b0;
        #1;
        chk_ready("midop_ready_after", 3'b100);
        cycle();
        bus.req_valid = '0;
        #1;
        chk_wr("midop_served", 1'b1, 5'd10, 32'hAA, 2'd2);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_rd    = '0;
        bus.req_data  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_x0_filter();
        test_same_rd();
        test_saturation();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (RegWrite / rd_addr / WriteData) between NREQ writeback sources, e.g. ALU writeback, load return and a multi-cycle mul/div unit.
- Round-robin arbitration with a valid/ready handshake per requester.
- One registered output stage drives the register file directly.
- Filters x0 writes and exposes the in-flight write for bypass/hazard logic.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- AW, 5, register address width.
- DW, 32, write data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  per-requester write request.
- req_rd  input  NREQ*AW  destination register; requester i occupies bits [i*AW +: AW].
- req_data  input  NREQ*DW  write data; requester i occupies bits [i*DW +: DW].
- req_ready  output  NREQ  request accepted this cycle; combinational.
- RegWrite  output  1  register file write enable; registered.
- rd_addr  output  AW  register file write address; registered.
- WriteData  output  DW  register file write data; registered.
- wb_src  output  clog2(NREQ)  index of the requester that owns the current RegWrite; registered.
- busy_cnt  output  8  saturating count of cycles in which at least one valid non-x0 request was not accepted; registered.

Behaviour:
- Reset (rst high at posedge):
  - RegWrite=0, rd_addr=0, WriteData=0, wb_src=0, busy_cnt=0.
  - RR pointer=NREQ-1, so requester 0 wins first.
  - req_ready is forced to all zeros while rst is high.
- Handshake:
  - Transfer on requester i occurs when req_valid[i] and req_ready[i] are both high at a posedge.
  - Once req_valid[i] is raised, requester i holds it, req_rd and req_data stable until the transfer.
  - The arbiter never asserts req_ready[i] while req_valid[i] is low.
- x0 filtering:
  - A valid request with req_rd==0 gets req_ready=1 in the same cycle.
  - It is independent of arbitration and consumes no grant.
  - It produces no RegWrite and does not move the RR pointer.
  - Several x0 requests may be acked in the same cycle.
- Arbitration among valid requests with req_rd!=0:
  - Exactly one is granted per cycle.
  - The search starts at pointer+1 and wraps modulo NREQ; the first valid index wins.
  - On a grant, the pointer becomes the winner's index.
  - With no grant, the pointer holds.
  - Any requester waits at most NREQ-1 cycles.
- Latency:
  - A grant at posedge N gives RegWrite=1, rd_addr, WriteData and wb_src of the winner during cycle N+1.
  - The register file captures it at posedge N+1.
  - Without a grant at posedge N, RegWrite=0 in cycle N+1; rd_addr, WriteData and wb_src hold their previous values.
- Throughput: one accepted non-x0 write per cycle; back-to-back grants are allowed with no bubble.
- Same rd from two requesters in one cycle:
  - Both are serialized in RR order; the later grant wins in the register file.
  - No merging or dropping.
- busy_cnt: increments by 1 in any cycle where the count of valid non-x0 requests is at least 2 (the losers stall); saturates at 255.
- Reset mid-operation:
  - A request pending at reset is not accepted and gets no req_ready.
  - A write registered before reset is cancelled: RegWrite=0 in the cycle after the reset edge.
  - Requesters keep req_valid and are served after reset, requester 0 first.

Test Plan:
- Reset, then req_valid=001 with rd=5 and data=0xDEADBEEF → req_ready=001 in the same cycle; next cycle RegWrite=1, rd_addr=5, WriteData=0xDEADBEEF, wb_src=0; following cycle RegWrite=0.
- req_valid=111 held for 6 cycles with rd=1/2/3 → grants in order 0,1,2,0,1,2; RegWrite high 6 consecutive cycles; busy_cnt increments on all 6 cycles.
- req_valid=011 with req0 rd=0 and req1 rd=7 → req_ready=011 in the same cycle; one write to rd 7 only; the RR pointer moves to 1, never to 0.
- Requesters 1 and 2 both target rd=4 with data 0x11 and 0x22, pointer=0 → writes 0x11 then 0x22 on consecutive cycles; a register-file readback of x4 gives 0x22.
- 300 cycles with req_valid=110 → busy_cnt saturates at 255 and does not wrap; grants alternate 1,2.
- rst asserted in the cycle after a grant to rd=9 → RegWrite=0 after the reset edge; a held req_valid=100 is then granted to requester 2 in the first cycle after reset.
